// File: rtl/med_seq.sv
// Sequences one 9-pixel window through the MED compare-exchange stage; median out 55 cycles after first pixel.
// No stall: DSI while busy is flagged in ERR and ignored, a broken load aborts the window.
module med_seq #(
  parameter int WIDTH = 8,
  parameter int NPIX  = 9
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] DI,
  input  logic             DSI,
  input  logic [WIDTH-1:0] MED_DO,
  output logic [WIDTH-1:0] MED_DI,
  output logic             MED_DSI,
  output logic             MED_BYP,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             READY,
  output logic             ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PASS,
    S_FINAL,
    S_CAPT
  } state_t;

  localparam logic [5:0] LOAD_LAST  = 6'(NPIX - 1);
  localparam logic [5:0] PASS_LAST  = 6'd44;
  localparam logic [5:0] FINAL_LAST = 6'd52;
  localparam logic [3:0] SUB_LAST   = 4'd8;

  state_t           r_state;
  logic [5:0]       r_n;
  logic [3:0]       r_sub;
  logic [WIDTH-1:0] r_med_di;
  logic             r_med_dsi;
  logic             r_med_byp;
  logic [WIDTH-1:0] r_do;
  logic             r_dso;
  logic             r_ready;
  logic             r_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_sub     <= '0;
      r_med_di  <= '0;
      r_med_dsi <= 1'b0;
      r_med_byp <= 1'b0;
      r_do      <= '0;
      r_dso     <= 1'b0;
      r_ready   <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_dso <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (DSI) begin
            r_state   <= S_LOAD;
            r_n       <= '0;
            r_med_di  <= DI;
            r_med_dsi <= 1'b1;
            r_med_byp <= 1'b1;
            r_ready   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (r_n == LOAD_LAST) begin
            r_state   <= S_PASS;
            r_n       <= r_n + 6'd1;
            r_sub     <= '0;
            r_med_dsi <= 1'b0;
            r_med_byp <= 1'b0;
          end else if (DSI) begin
            r_n      <= r_n + 6'd1;
            r_med_di <= DI;
          end else begin
            // Short window: MED holds a partial load, so drop it and report.
            r_err     <= 1'b1;
            r_state   <= S_IDLE;
            r_med_dsi <= 1'b0;
            r_med_byp <= 1'b0;
            r_ready   <= 1'b1;
          end
        end
        S_PASS: begin
          if (DSI) r_err <= 1'b1;
          r_n <= r_n + 6'd1;
          if (r_n == PASS_LAST) begin
            r_state   <= S_FINAL;
            r_med_byp <= 1'b0;
          end else begin
            // Last slot of each 9-step pass bypasses, dropping the pass maximum.
            r_sub     <= (r_sub == SUB_LAST) ? 4'd0 : r_sub + 4'd1;
            r_med_byp <= (r_sub == SUB_LAST - 4'd1);
          end
        end
        S_FINAL: begin
          if (DSI) r_err <= 1'b1;
          r_n <= r_n + 6'd1;
          if (r_n == FINAL_LAST) r_state <= S_CAPT;
        end
        S_CAPT: begin
          if (DSI) r_err <= 1'b1;
          r_do    <= MED_DO;
          r_dso   <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MED_DI  = r_med_di;
  assign MED_DSI = r_med_dsi;
  assign MED_BYP = r_med_byp;
  assign DO      = r_do;
  assign DSO     = r_dso;
  assign READY   = r_ready;
  assign ERR     = r_err;

endmodule
